alu_seq: RTL and testbench

- Parametrised, handshaked successor to the 16-bit combinational adder/subtractor ALU.
- Accepts one operation at a time over a valid/ready input channel.
- Holds an architectural NZVC flag register. ADC/SBC take their carry from that register rather than from a port.
- Returns a registered result over a valid/ready output channel. Single-cycle ops have 1-cycle latency; the optional multiply is iterative.

---
 rtl/alu_seq.sv | 197 +++++++++++++++++++
 tb/tb_alu_seq.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Handshaked sequential ALU with an architectural NZVC flag register.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add MUL (opcode 10).
module alu_seq #(
   parameter  int unsigned WIDTH = 16,
   localparam int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flags_ld,
   input  logic [3:0]       flags_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       nzvc
);

   localparam int unsigned W1  = WIDTH + 1;
   localparam int unsigned MSB = WIDTH - 1;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_ADC = 4'd2;
   localparam logic [3:0] OP_SBC = 4'd3;
   localparam logic [3:0] OP_AND = 4'd4;
   localparam logic [3:0] OP_OR  = 4'd5;
   localparam logic [3:0] OP_XOR = 4'd6;
   localparam logic [3:0] OP_SHL = 4'd7;
   localparam logic [3:0] OP_SHR = 4'd8;
   localparam logic [3:0] OP_ASR = 4'd9;
`ifdef ALU_SEQ_MUL_EN
   localparam logic [3:0] OP_MUL = 4'd10;
   localparam int unsigned CW    = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
`else
   typedef enum logic [0:0] {IDLE = 1'b0, DONE = 1'b1} state_t;
`endif

   state_t           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [3:0]       nzvc_q, nzvc_d;

   logic [WIDTH-1:0] bop;
   logic             cin;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shl_t, shr_t, asr_t;
   logic [SHW-1:0]   s;
   logic [WIDTH-1:0] alu_res;
   logic [3:0]       alu_nzvc;
   logic             nz_wr;

`ifdef ALU_SEQ_MUL_EN
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH:0]     mul_sum;

   // Add multiplicand into the upper half when the current multiplier bit is set.
   assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
`endif

   assign s         = b[SHW-1:0];
   assign in_ready  = (state_q == IDLE) & ~flags_ld & ~rst;
   assign out_valid = (state_q == DONE);
   assign result    = result_q;
   assign nzvc      = nzvc_q;

   // Single-cycle datapath; subtraction is A + ~B + cin so C=1 means no borrow.
   always_comb begin
      bop = b;
      cin = 1'b0;
      case (op)
         OP_SUB:  begin bop = ~b; cin = 1'b1;      end
         OP_ADC:  cin = nzvc_q[0];
         OP_SBC:  begin bop = ~b; cin = nzvc_q[0]; end
         default: ;
      endcase
      sum   = {1'b0, a} + {1'b0, bop} + W1'(cin);
      shl_t = {1'b0, a} << s;
      shr_t = {a, 1'b0} >> s;
      asr_t = W1'($signed({a, 1'b0}) >>> s);

      alu_res  = '0;
      alu_nzvc = nzvc_q;
      nz_wr    = 1'b0;
      case (op)
         OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
            alu_res     = sum[WIDTH-1:0];
            nz_wr       = 1'b1;
            alu_nzvc[1] = (a[MSB] == bop[MSB]) && (sum[MSB] != a[MSB]);
            alu_nzvc[0] = sum[WIDTH];
         end
         OP_AND: begin alu_res = a & b; nz_wr = 1'b1; end
         OP_OR:  begin alu_res = a | b; nz_wr = 1'b1; end
         OP_XOR: begin alu_res = a ^ b; nz_wr = 1'b1; end
         OP_SHL: begin
            alu_res = shl_t[WIDTH-1:0];
            nz_wr   = 1'b1;
            if (s != '0) alu_nzvc[0] = shl_t[WIDTH];
         end
         OP_SHR: begin
            alu_res = shr_t[WIDTH:1];
            nz_wr   = 1'b1;
            if (s != '0) alu_nzvc[0] = shr_t[0];
         end
         OP_ASR: begin
            alu_res = asr_t[WIDTH:1];
            nz_wr   = 1'b1;
            if (s != '0) alu_nzvc[0] = asr_t[0];
         end
         default: ;
      endcase
      if (nz_wr) begin
         alu_nzvc[3] = alu_res[MSB];
         alu_nzvc[2] = (alu_res == '0);
      end
   end

   // Next-state and register-update logic.
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      nzvc_d   = nzvc_q;
`ifdef ALU_SEQ_MUL_EN
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      cnt_d    = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (flags_ld) begin
               nzvc_d = flags_in;
            end else if (in_valid && in_ready) begin
`ifdef ALU_SEQ_MUL_EN
               if (op == OP_MUL) begin
                  state_d = BUSY;
                  acc_d   = {{WIDTH{1'b0}}, b};
                  mcand_d = a;
                  cnt_d   = '0;
               end else
`endif
               begin
                  state_d  = DONE;
                  result_d = alu_res;
                  nzvc_d   = alu_nzvc;
               end
            end
         end
`ifdef ALU_SEQ_MUL_EN
         // WIDTH shift-add steps, then one cycle to publish product and flags.
         BUSY: begin
            if (cnt_q == CW'(WIDTH)) begin
               state_d  = DONE;
               result_d = acc_q[WIDTH-1:0];
               nzvc_d   = {acc_q[MSB], (acc_q[WIDTH-1:0] == '0), 1'b0,
                           |acc_q[2*WIDTH-1:WIDTH]};
            end else begin
               acc_d = {mul_sum, acc_q[WIDTH-1:1]};
               cnt_d = cnt_q + CW'(1);
            end
         end
`endif
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         result_q <= '0;
         nzvc_q   <= 4'b0000;
`ifdef ALU_SEQ_MUL_EN
         acc_q    <= '0;
         mcand_q  <= '0;
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         nzvc_q   <= nzvc_d;
`ifdef ALU_SEQ_MUL_EN
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         cnt_q    <= cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=16.
// MUL checks follow ALU_SEQ_MUL_EN; without it MUL is checked as a reserved opcode.
module tb_alu_seq;

   localparam int unsigned WIDTH = 16;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_ADC = 4'd2;
   localparam logic [3:0] OP_SBC = 4'd3;
   localparam logic [3:0] OP_AND = 4'd4;
   localparam logic [3:0] OP_OR  = 4'd5;
   localparam logic [3:0] OP_XOR = 4'd6;
   localparam logic [3:0] OP_SHL = 4'd7;
   localparam logic [3:0] OP_SHR = 4'd8;
   localparam logic [3:0] OP_ASR = 4'd9;
   localparam logic [3:0] OP_MUL = 4'd10;
   localparam logic [3:0] OP_RSV = 4'd11;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flags_ld;
   logic [3:0]       flags_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [3:0]       nzvc;

   int errors = 0;
   int checks = 0;

   alu_seq #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
      .flags_ld(flags_ld), .flags_in(flags_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .nzvc(nzvc)
   );

   always #5 clk = ~clk;

   task automatic send(input logic [3:0] o, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb);
      @(negedge clk);
      in_valid = 1'b1; op = o; a = va; b = vb;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic load_flags(input logic [3:0] v);
      @(negedge clk);
      flags_ld = 1'b1; flags_in = v;
      @(posedge clk); #1;
      flags_ld = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; op = OP_ADD; a = 16'h0001; b = 16'h0001;
      flags_ld = 1'b0; flags_in = 4'h0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
      @(negedge clk); rst = 1'b0; in_valid = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      checks++; if (result !== 16'h0000) begin errors++; $display("FAIL rst_result: got %h want 0000", result); end
      checks++; if (nzvc !== 4'b0000) begin errors++; $display("FAIL rst_nzvc: got %b want 0000", nzvc); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_idle_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_add();
      send(OP_ADD, 16'h7FFF, 16'h0001);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b want 1", out_valid); end
      checks++; if (result !== 16'h8000) begin errors++; $display("FAIL add_result: got %h want 8000", result); end
      checks++; if (nzvc !== 4'b1010) begin errors++; $display("FAIL add_nzvc: got %b want 1010", nzvc); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL add_done_ready: got %b want 0", in_ready); end
      drain();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain_valid: got %b want 0", out_valid); end
   endtask

   task automatic test_sub_sbc();
      send(OP_SUB, 16'h0000, 16'h0001);
      checks++; if (result !== 16'hFFFF) begin errors++; $display("FAIL sub_result: got %h want ffff", result); end
      checks++; if (nzvc !== 4'b1000) begin errors++; $display("FAIL sub_nzvc: got %b want 1000", nzvc); end
      drain();
      // flags_ld with in_valid high must load flags and refuse the op
      @(negedge clk);
      flags_ld = 1'b1; flags_in = 4'b0000; in_valid = 1'b1; op = OP_ADD; a = 16'h0001; b = 16'h0001;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fld_blocks_ready: got %b want 0", in_ready); end
      @(posedge clk); #1;
      flags_ld = 1'b0; in_valid = 1'b0;
      checks++; if (nzvc !== 4'b0000) begin errors++; $display("FAIL fld_nzvc: got %b want 0000", nzvc); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fld_no_accept: got %b want 0", out_valid); end
      send(OP_SBC, 16'h0005, 16'h0003);
      checks++; if (result !== 16'h0001) begin errors++; $display("FAIL sbc_result: got %h want 0001", result); end
      checks++; if (nzvc !== 4'b0001) begin errors++; $display("FAIL sbc_nzvc: got %b want 0001", nzvc); end
      drain();
   endtask

   task automatic test_logic();
      load_flags(4'b0011);
      send(OP_AND, 16'hF0F0, 16'h8F00);
      checks++; if (result !== 16'h8000) begin errors++; $display("FAIL and_result: got %h want 8000", result); end
      checks++; if (nzvc !== 4'b1011) begin errors++; $display("FAIL and_nzvc: got %b want 1011", nzvc); end
      drain();
      send(OP_XOR, 16'h1234, 16'h1234);
      checks++; if (result !== 16'h0000) begin errors++; $display("FAIL xor_result: got %h want 0000", result); end
      checks++; if (nzvc !== 4'b0111) begin errors++; $display("FAIL xor_nzvc: got %b want 0111", nzvc); end
      drain();
      send(OP_OR, 16'h0001, 16'h0002);
      checks++; if (result !== 16'h0003) begin errors++; $display("FAIL or_result: got %h want 0003", result); end
      checks++; if (nzvc !== 4'b0011) begin errors++; $display("FAIL or_nzvc: got %b want 0011", nzvc); end
      drain();
   endtask

   task automatic test_shift();
      load_flags(4'b0000);
      send(OP_SHL, 16'h8001, 16'h0001);
      checks++; if (result !== 16'h0002) begin errors++; $display("FAIL shl_result: got %h want 0002", result); end
      checks++; if (nzvc !== 4'b0001) begin errors++; $display("FAIL shl_nzvc: got %b want 0001", nzvc); end
      drain();
      send(OP_SHR, 16'h0004, 16'h0000);
      checks++; if (result !== 16'h0004) begin errors++; $display("FAIL shr0_result: got %h want 0004", result); end
      checks++; if (nzvc !== 4'b0001) begin errors++; $display("FAIL shr0_nzvc: got %b want 0001", nzvc); end
      drain();
      send(OP_ASR, 16'h8004, 16'h0003);
      checks++; if (result !== 16'hF000) begin errors++; $display("FAIL asr_result: got %h want f000", result); end
      checks++; if (nzvc !== 4'b1001) begin errors++; $display("FAIL asr_nzvc: got %b want 1001", nzvc); end
      drain();
      send(OP_SHR, 16'h8004, 16'h0002);
      checks++; if (result !== 16'h2001) begin errors++; $display("FAIL shr_result: got %h want 2001", result); end
      checks++; if (nzvc !== 4'b0000) begin errors++; $display("FAIL shr_nzvc: got %b want 0000", nzvc); end
      drain();
      // only b[3:0] is the shift amount
      send(OP_SHL, 16'h0001, 16'h0014);
      checks++; if (result !== 16'h0010) begin errors++; $display("FAIL shl_amt_result: got %h want 0010", result); end
      drain();
   endtask

   task automatic test_reserved();
      load_flags(4'b0101);
      send(OP_RSV, 16'h0005, 16'h0005);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rsv_valid: got %b want 1", out_valid); end
      checks++; if (result !== 16'h0000) begin errors++; $display("FAIL rsv_result: got %h want 0000", result); end
      checks++; if (nzvc !== 4'b0101) begin errors++; $display("FAIL rsv_nzvc: got %b want 0101", nzvc); end
      drain();
`ifndef ALU_SEQ_MUL_EN
      send(OP_ADD, 16'h0001, 16'h0001);
      drain();
      load_flags(4'b1010);
      send(OP_MUL, 16'h0003, 16'h0003);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mulrsv_valid: got %b want 1", out_valid); end
      checks++; if (result !== 16'h0000) begin errors++; $display("FAIL mulrsv_result: got %h want 0000", result); end
      checks++; if (nzvc !== 4'b1010) begin errors++; $display("FAIL mulrsv_nzvc: got %b want 1010", nzvc); end
      drain();
`endif
   endtask

   task automatic test_backpressure();
      send(OP_ADD, 16'h0002, 16'h0003);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++; if (result !== 16'h0005 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_hold%0d: got res=%h ov=%b ir=%b want 0005 1 0", i, result, out_valid, in_ready);
         end
      end
      drain();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_back_to_back();
      load_flags(4'b0001);
      @(negedge clk);
      in_valid = 1'b1; op = OP_ADC; a = 16'h0001; b = 16'h0002; out_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || result !== 16'h0004 || nzvc !== 4'b0000) begin
         errors++; $display("FAIL b2b_first: got ov=%b res=%h nzvc=%b want 1 0004 0000", out_valid, result, nzvc);
      end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap: got %b want 0", out_valid); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || result !== 16'h0003) begin
         errors++; $display("FAIL b2b_second: got ov=%b res=%h want 1 0003", out_valid, result);
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b want 0", out_valid); end
   endtask

`ifdef ALU_SEQ_MUL_EN
   task automatic test_mul();
      int    n;
      logic  seen_ready;
      load_flags(4'b0000);
      n = 0; seen_ready = 1'b0;
      send(OP_MUL, 16'h0100, 16'h0100);
      while (out_valid !== 1'b1 && n < 40) begin
         if (in_ready !== 1'b0) seen_ready = 1'b1;
         @(posedge clk); #1;
         n++;
      end
      checks++; if (n !== 17) begin errors++; $display("FAIL mul_latency: got %0d want 17", n); end
      checks++; if (seen_ready !== 1'b0) begin errors++; $display("FAIL mul_busy_ready: got %b want 0", seen_ready); end
      checks++; if (result !== 16'h0000) begin errors++; $display("FAIL mul1_result: got %h want 0000", result); end
      checks++; if (nzvc !== 4'b0101) begin errors++; $display("FAIL mul1_nzvc: got %b want 0101", nzvc); end
      drain();
      n = 0;
      send(OP_MUL, 16'h00FF, 16'h0003);
      while (out_valid !== 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      checks++; if (n !== 17) begin errors++; $display("FAIL mul2_latency: got %0d want 17", n); end
      checks++; if (result !== 16'h02FD) begin errors++; $display("FAIL mul2_result: got %h want 02fd", result); end
      checks++; if (nzvc !== 4'b0000) begin errors++; $display("FAIL mul2_nzvc: got %b want 0000", nzvc); end
      drain();
   endtask
`endif

   task automatic test_rst_abort();
      load_flags(4'b1111);
`ifdef ALU_SEQ_MUL_EN
      send(OP_MUL, 16'h0003, 16'h0005);
`else
      send(OP_ADD, 16'h0002, 16'h0003);
`endif
      repeat (4) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++; if (out_valid !== 1'b0 || nzvc !== 4'b0000 || result !== 16'h0000) begin
         errors++; $display("FAIL abort_state: got ov=%b nzvc=%b res=%h want 0 0000 0000", out_valid, nzvc, result);
      end
      repeat (20) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_stale_valid: got %b want 0", out_valid); end
      send(OP_ADD, 16'hFFFF, 16'h0001);
      checks++; if (out_valid !== 1'b1 || result !== 16'h0000 || nzvc !== 4'b0101) begin
         errors++; $display("FAIL abort_next_add: got ov=%b res=%h nzvc=%b want 1 0000 0101", out_valid, result, nzvc);
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub_sbc();
      test_logic();
      test_shift();
      test_reserved();
      test_backpressure();
      test_back_to_back();
`ifdef ALU_SEQ_MUL_EN
      test_mul();
`endif
      test_rst_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
